// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl
// Dispatch stage between rename and the ALU / branch / LSU reservation
// stations. One renamed instruction is buffered in a holding register and
// steered to the reservation station named by its FU field. The ROB entry is
// allocated in the same cycle. The block also owns the physical-register
// ready table and the post-mispredict flush window.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   rn_valid/rn_ready   rename handshake (transfer = rn_valid & rn_ready)
//   rn_data             opaque payload, carried unmodified to di_data
//   rn_fu               target RS: 0 ALU, 1 branch, 2 LSU, 3 illegal
//   rn_has_rd/rn_pd_new destination write flag and physical register
//   rs_full             per-RS full, bit order {LSU, BR, ALU}
//   rob_full            ROB cannot allocate
//   di_en               one-hot dispatch strobe, combinational on fire
//   di_data             held payload presented to the reservation stations
//   rob_alloc           ROB allocate strobe, coincident with di_en
//   cdb_valid/cdb_pd    writeback broadcast marking a register ready
//   mispredict          branch recovery pulse
//   preg_rtable         registered ready bit per physical register
//   stall_cnt           saturating count of cycles a held instruction waited
module dispatch_ctrl #(
    parameter int NUM_PREG     = 128,
    parameter int DATA_W       = 128,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rn_valid,
    output logic                rn_ready,
    input  logic [DATA_W-1:0]   rn_data,
    input  logic [1:0]          rn_fu,
    input  logic                rn_has_rd,
    input  logic [6:0]          rn_pd_new,
    input  logic [2:0]          rs_full,
    input  logic                rob_full,
    output logic [2:0]          di_en,
    output logic [DATA_W-1:0]   di_data,
    output logic                rob_alloc,
    input  logic                cdb_valid,
    input  logic [6:0]          cdb_pd,
    input  logic                mispredict,
    output logic [NUM_PREG-1:0] preg_rtable,
    output logic [15:0]         stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [3:0]            flush_cnt_r;
    logic [3:0]            flush_cnt_nxt_s;

    logic                  hold_valid_r;
    logic [DATA_W-1:0]     hold_data_r;
    logic [1:0]            hold_fu_r;
    logic                  hold_has_rd_r;
    logic [6:0]            hold_pd_r;

    logic [NUM_PREG-1:0]   rtable_r;
    logic [NUM_PREG-1:0]   rtable_nxt_s;
    logic [15:0]           stall_cnt_r;

    logic                  run_s;
    logic                  rs_blk_s;
    logic                  fire_s;
    logic                  drop_s;
    logic                  ready_s;
    logic                  xfer_s;
    logic [2:0]            di_en_s;

    // Dispatch decision: legality, back-pressure and the one-hot strobe.
    always_comb begin
        run_s    = 1'b0;
        rs_blk_s = 1'b1;
        fire_s   = 1'b0;
        drop_s   = 1'b0;
        ready_s  = 1'b0;
        xfer_s   = 1'b0;
        di_en_s  = 3'b000;

        run_s = (state_r == ST_RUN);

        // An illegal FU counts as blocked so it can never fire.
        case (hold_fu_r)
            2'd0:    rs_blk_s = rs_full[0];
            2'd1:    rs_blk_s = rs_full[1];
            2'd2:    rs_blk_s = rs_full[2];
            default: rs_blk_s = 1'b1;
        endcase

        fire_s = hold_valid_r & run_s & ~mispredict & ~rob_full & ~rs_blk_s;
        // Illegal-FU instructions are discarded one cycle after acceptance.
        drop_s = hold_valid_r & run_s & ~mispredict & (hold_fu_r == 2'd3);

        ready_s = run_s & ~mispredict & (~hold_valid_r | fire_s | drop_s);
        xfer_s  = rn_valid & ready_s;

        if (fire_s) begin
            case (hold_fu_r)
                2'd0:    di_en_s = 3'b001;
                2'd1:    di_en_s = 3'b010;
                2'd2:    di_en_s = 3'b100;
                default: di_en_s = 3'b000;
            endcase
        end else begin
            di_en_s = 3'b000;
        end
    end

    assign rn_ready    = ready_s;
    assign di_en       = di_en_s;
    assign rob_alloc   = fire_s;
    assign di_data     = hold_data_r;
    assign preg_rtable = rtable_r;
    assign stall_cnt   = stall_cnt_r;

    // FSM next state: mispredict (re)starts the blackout from any state.
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        if (mispredict) begin
            state_nxt_s     = ST_FLUSH;
            flush_cnt_nxt_s = 4'(FLUSH_CYCLES);
        end else begin
            case (state_r)
                ST_RUN: begin
                    state_nxt_s     = ST_RUN;
                    flush_cnt_nxt_s = 4'd0;
                end
                ST_FLUSH: begin
                    if (flush_cnt_r <= 4'd1) begin
                        state_nxt_s     = ST_RUN;
                        flush_cnt_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s     = ST_FLUSH;
                        flush_cnt_nxt_s = flush_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s     = ST_RUN;
                    flush_cnt_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // FSM state and flush counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
        end
    end

    // Holding register: mispredict discards, a transfer loads (also when the
    // current occupant leaves the same cycle), fire or drop empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_r  <= 1'b0;
            hold_data_r   <= '0;
            hold_fu_r     <= 2'd0;
            hold_has_rd_r <= 1'b0;
            hold_pd_r     <= 7'd0;
        end else if (mispredict) begin
            hold_valid_r  <= 1'b0;
        end else if (xfer_s) begin
            hold_valid_r  <= 1'b1;
            hold_data_r   <= rn_data;
            hold_fu_r     <= rn_fu;
            hold_has_rd_r <= rn_has_rd;
            hold_pd_r     <= rn_pd_new;
        end else if (fire_s | drop_s) begin
            hold_valid_r  <= 1'b0;
        end else begin
            hold_valid_r  <= hold_valid_r;
        end
    end

    // Ready-table next value: writeback sets, dispatch clears afterwards so
    // a same-cycle collision leaves the register not ready; p0 stays ready.
    always_comb begin
        rtable_nxt_s = rtable_r;
        if (cdb_valid && (cdb_pd != 7'd0)) begin
            rtable_nxt_s[cdb_pd] = 1'b1;
        end else begin
            rtable_nxt_s = rtable_nxt_s;
        end
        if (fire_s && hold_has_rd_r && (hold_pd_r != 7'd0)) begin
            rtable_nxt_s[hold_pd_r] = 1'b0;
        end else begin
            rtable_nxt_s = rtable_nxt_s;
        end
        rtable_nxt_s[0] = 1'b1;
    end

    // Ready-table register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtable_r <= '1;
        end else begin
            rtable_r <= rtable_nxt_s;
        end
    end

    // Saturating stall counter: held instruction waiting while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
        end else if (hold_valid_r && run_s && !fire_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule
